// File: rtl/up_down_counter_pkg.sv
// Shared constants for the up/down counter.
// Direction encodings and the default counter width.
package up_down_counter_pkg;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/up_down_counter.sv
// Free-running modulo-2^WIDTH binary counter.
// Direction is a level input; the count updates on every rising edge.
module up_down_counter
   import up_down_counter_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             Clk,
   input  logic             reset,
   input  logic             UpOrDown,
   output logic [WIDTH-1:0] Count
);

   logic [WIDTH-1:0] step;
   logic [WIDTH-1:0] count_nxt;

   // All-ones is -1 modulo 2^WIDTH, so one adder serves both directions
   always_comb begin
      step      = (UpOrDown == DIR_UP) ? WIDTH'(1) : '1;
      count_nxt = Count + step;
   end

   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) begin
         Count <= '0;
      end else begin
         Count <= count_nxt;
      end
   end

endmodule

// File: tb/tb_up_down_counter.sv
// Testbench for up_down_counter: WIDTH=4 and WIDTH=8 instances
// checked against directed vectors and a per-cycle reference model.
module tb_up_down_counter;

   logic       Clk;
   logic       reset;
   logic       UpOrDown;
   logic [3:0] c4;
   logic [7:0] c8;

   logic [3:0] m4;
   logic [7:0] m8;

   int n_chk;
   int n_fail;

   typedef struct {
      logic       rst;
      logic       dir;
      logic [3:0] exp;
   } vec_t;

   vec_t vecs[15];

   up_down_counter #(.WIDTH(4)) dut4 (
      .Clk      (Clk),
      .reset    (reset),
      .UpOrDown (UpOrDown),
      .Count    (c4)
   );

   up_down_counter #(.WIDTH(8)) dut8 (
      .Clk      (Clk),
      .reset    (reset),
      .UpOrDown (UpOrDown),
      .Count    (c8)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle's inputs, step the model, compare both DUTs
   task automatic cyc(input logic r, input logic d);
      reset    = r;
      UpOrDown = d;
      @(posedge Clk);
      #1;
      if (!r) begin
         m4 = '0;
         m8 = '0;
      end else if (d) begin
         m4 = m4 + 4'd1;
         m8 = m8 + 8'd1;
      end else begin
         m4 = m4 - 4'd1;
         m8 = m8 - 8'd1;
      end
      chk("model4", int'(c4), int'(m4));
      chk("model8", int'(c8), int'(m8));
   endtask

   initial begin
      n_chk    = 0;
      n_fail   = 0;
      m4       = '0;
      m8       = '0;
      reset    = 1'b0;
      UpOrDown = 1'b1;

      vecs[0]  = '{1'b0, 1'b1, 4'd0};
      vecs[1]  = '{1'b0, 1'b0, 4'd0};
      vecs[2]  = '{1'b0, 1'b1, 4'd0};
      vecs[3]  = '{1'b1, 1'b0, 4'd15};
      vecs[4]  = '{1'b1, 1'b0, 4'd14};
      vecs[5]  = '{1'b1, 1'b0, 4'd13};
      vecs[6]  = '{1'b1, 1'b1, 4'd14};
      vecs[7]  = '{1'b1, 1'b1, 4'd15};
      vecs[8]  = '{1'b1, 1'b1, 4'd0};
      vecs[9]  = '{1'b1, 1'b1, 4'd1};
      vecs[10] = '{1'b1, 1'b0, 4'd0};
      vecs[11] = '{1'b1, 1'b0, 4'd15};
      vecs[12] = '{1'b0, 1'b0, 4'd0};
      vecs[13] = '{1'b1, 1'b1, 4'd1};
      vecs[14] = '{1'b1, 1'b1, 4'd2};

      #1;
      chk("reset_initial4", int'(c4), 0);
      chk("reset_initial8", int'(c8), 0);

      for (int i = 0; i < 15; i++) begin
         cyc(vecs[i].rst, vecs[i].dir);
         chk($sformatf("vec%0d", i), int'(c4), int'(vecs[i].exp));
      end

      // Down count from 0 for 30 cycles
      cyc(1'b0, 1'b0);
      for (int i = 0; i < 30; i++) begin
         cyc(1'b1, 1'b0);
         if (i == 0)  chk("down_wrap4", int'(c4), 15);
         if (i == 0)  chk("down_wrap8", int'(c8), 255);
         if (i == 15) chk("down_zero4", int'(c4), 0);
         if (i == 16) chk("down_wrap4b", int'(c4), 15);
      end

      // Up count from 3 for 30 cycles
      cyc(1'b0, 1'b1);
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1);
      chk("up_start", int'(c4), 3);
      for (int i = 0; i < 30; i++) begin
         cyc(1'b1, 1'b1);
         if (i == 11) chk("up_top4", int'(c4), 15);
         if (i == 12) chk("up_wrap4", int'(c4), 0);
         if (i == 12) chk("up_no_wrap8", int'(c8), 16);
      end

      // Direction flips
      cyc(1'b0, 1'b1);
      for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1);
      chk("flip_at6", int'(c4), 6);
      cyc(1'b1, 1'b0);
      chk("flip_down", int'(c4), 5);
      cyc(1'b1, 1'b0);
      chk("flip_at4", int'(c4), 4);
      cyc(1'b1, 1'b1);
      chk("flip_up", int'(c4), 5);

      // Asynchronous reset mid-count, held, then released counting down
      cyc(1'b0, 1'b1);
      for (int i = 0; i < 9; i++) cyc(1'b1, 1'b1);
      chk("mid_at9", int'(c4), 9);
      reset = 1'b0;
      #2;
      chk("async_clr4", int'(c4), 0);
      chk("async_clr8", int'(c8), 0);
      m4 = '0;
      m8 = '0;
      for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1);
      chk("held_zero", int'(c4), 0);
      cyc(1'b1, 1'b0);
      chk("release_down4", int'(c4), 15);
      chk("release_down8", int'(c8), 255);
      cyc(1'b1, 1'b0);
      chk("release_next4", int'(c4), 14);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
